// File: rtl/ring_decoder.sv
// ring_decoder: samples a rotating one-hot ring vector, encodes its index,
// verifies each accepted sample is a single right-rotate of the previous one,
// locks after LOCK_CNT consecutive good steps, and counts rotations/errors.
//
// state  | meaning
// SEARCH | hunting for LOCK_CNT consecutive legal rotations
// LOCKED | sequence tracked; wraps counted, any bad sample is an error
module ring_decoder #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  localparam int IDXW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             clr_cnt,
  output logic [IDXW-1:0]  idx,
  output logic             idx_valid,
  output logic             locked,
  output logic             wrap,
  output logic             err,
  output logic [7:0]       err_cnt,
  output logic [15:0]      rot_cnt
);

  localparam int GW = $clog2(LOCK_CNT + 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] prev, prev_nxt;
  logic             have_prev, have_prev_nxt;
  logic [GW-1:0]    good_cnt, good_cnt_nxt;
  logic [IDXW-1:0]  idx_nxt;
  logic             idx_valid_nxt, wrap_nxt, err_nxt;
  logic [7:0]       err_cnt_nxt;
  logic [15:0]      rot_cnt_nxt;

  logic [WIDTH-1:0] expected;
  logic [WIDTH-1:0] ring_m1;
  logic             onehot;
  logic             match;
  logic [IDXW-1:0]  enc;
  logic [GW-1:0]    good_inc;

  // Expected next sample is the right-rotate of the last accepted one.
  assign expected = {prev[0], prev[WIDTH-1:1]};
  assign ring_m1  = ring_in - {{(WIDTH-1){1'b0}}, 1'b1};
  assign onehot   = (|ring_in) && ~(|(ring_in & ring_m1));
  assign match    = (ring_in == expected);
  assign good_inc = good_cnt + GW'(1);
  assign locked   = (state == LOCKED);

  // Binary encoder of the set bit; only used when ring_in is one-hot.
  always_comb begin
    enc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ring_in[i]) enc = IDXW'(i);
    end
  end

  // Next-state and registered-output logic for the sequence tracker.
  always_comb begin
    state_nxt     = state;
    prev_nxt      = prev;
    have_prev_nxt = have_prev;
    good_cnt_nxt  = good_cnt;
    idx_nxt       = idx;
    idx_valid_nxt = idx_valid;
    wrap_nxt      = 1'b0;
    err_nxt       = 1'b0;
    err_cnt_nxt   = err_cnt;
    rot_cnt_nxt   = rot_cnt;

    if (en) begin
      idx_valid_nxt = onehot;
      if (onehot) begin
        idx_nxt  = enc;
        prev_nxt = ring_in;
      end
      case (state)
        SEARCH: begin
          if (!onehot) begin
            good_cnt_nxt  = '0;
            have_prev_nxt = 1'b0;
          end else if (have_prev && match) begin
            good_cnt_nxt = good_inc;
            if (good_inc == GW'(LOCK_CNT)) state_nxt = LOCKED;
          end else begin
            good_cnt_nxt  = '0;
            have_prev_nxt = 1'b1;
          end
        end
        LOCKED: begin
          if (match) begin
            // prev at bit 0 means this step wraps to the top bit
            if (prev[0]) begin
              wrap_nxt    = 1'b1;
              rot_cnt_nxt = rot_cnt + 16'd1;
            end
          end else begin
            err_nxt       = 1'b1;
            if (err_cnt != 8'hFF) err_cnt_nxt = err_cnt + 8'd1;
            state_nxt     = SEARCH;
            good_cnt_nxt  = '0;
            have_prev_nxt = onehot;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end

    // Clear beats a coincident increment; pulses are unaffected.
    if (clr_cnt) begin
      err_cnt_nxt = '0;
      rot_cnt_nxt = '0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEARCH;
      prev      <= '0;
      have_prev <= 1'b0;
      good_cnt  <= '0;
      idx       <= '0;
      idx_valid <= 1'b0;
      wrap      <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
      rot_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      prev      <= prev_nxt;
      have_prev <= have_prev_nxt;
      good_cnt  <= good_cnt_nxt;
      idx       <= idx_nxt;
      idx_valid <= idx_valid_nxt;
      wrap      <= wrap_nxt;
      err       <= err_nxt;
      err_cnt   <= err_cnt_nxt;
      rot_cnt   <= rot_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_ring_decoder.sv
// Scoreboard bench for ring_decoder (WIDTH=4, LOCK_CNT=2). A behavioural
// reference model computes expected outputs as each sample is driven; they
// are queued and compared one cycle later against the DUT.
module tb_ring_decoder;

  logic        clk = 1'b0;
  logic        rst, en, clr_cnt;
  logic [3:0]  ring_in;
  logic [1:0]  idx;
  logic        idx_valid, locked, wrap, err;
  logic [7:0]  err_cnt;
  logic [15:0] rot_cnt;

  ring_decoder #(.WIDTH(4), .LOCK_CNT(2)) dut (
    .clk(clk), .rst(rst), .en(en), .ring_in(ring_in), .clr_cnt(clr_cnt),
    .idx(idx), .idx_valid(idx_valid), .locked(locked), .wrap(wrap),
    .err(err), .err_cnt(err_cnt), .rot_cnt(rot_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  idx;
    logic        iv;
    logic        locked;
    logic        wrap;
    logic        err;
    logic [7:0]  err_cnt;
    logic [15:0] rot_cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // reference model state
  logic        m_locked = 1'b0;
  logic [3:0]  m_prev   = '0;
  logic        m_have   = 1'b0;
  int          m_good   = 0;
  logic [1:0]  m_idx    = '0;
  logic        m_iv     = 1'b0;
  logic [7:0]  m_errc   = '0;
  logic [15:0] m_rotc   = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model of one clock edge; returns the expected outputs.
  function automatic exp_t model(input logic r, input logic e, input logic c, input logic [3:0] v);
    exp_t o;
    logic oh;
    logic [3:0] nxt;
    logic w, er;
    w  = 1'b0;
    er = 1'b0;
    if (r) begin
      m_locked = 0; m_prev = 0; m_have = 0; m_good = 0;
      m_idx = 0; m_iv = 0; m_errc = 0; m_rotc = 0;
    end else begin
      if (e) begin
        oh  = ($countones(v) == 1);
        nxt = {m_prev[0], m_prev[3:1]};
        m_iv = oh;
        if (!m_locked) begin
          if (!oh) begin m_good = 0; m_have = 0; end
          else if (m_have && v == nxt) begin
            m_good++;
            if (m_good == 2) m_locked = 1;
          end else begin m_good = 0; m_have = 1; end
        end else begin
          if (v == nxt) begin
            if (m_prev == 4'b0001) begin w = 1; m_rotc++; end
          end else begin
            er = 1;
            if (m_errc < 255) m_errc++;
            m_locked = 0; m_good = 0; m_have = oh;
          end
        end
        if (oh) begin
          m_prev = v;
          for (int i = 0; i < 4; i++) if (v[i]) m_idx = 2'(i);
        end
      end
      if (c) begin m_errc = 0; m_rotc = 0; end
    end
    o.idx = m_idx; o.iv = m_iv; o.locked = m_locked; o.wrap = w; o.err = er;
    o.err_cnt = m_errc; o.rot_cnt = m_rotc;
    return o;
  endfunction

  // Drive one cycle, push model expectation, then pop and compare after the edge.
  task automatic step(input logic r, input logic e, input logic c, input logic [3:0] v);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; clr_cnt = c; ring_in = v;
    sb_q.push_back(model(r, e, c, v));
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL scoreboard_empty");
    end else begin
      x = sb_q.pop_front();
      check_val("idx",       32'(idx),       32'(x.idx));
      check_val("idx_valid", 32'(idx_valid), 32'(x.iv));
      check_val("locked",    32'(locked),    32'(x.locked));
      check_val("wrap",      32'(wrap),      32'(x.wrap));
      check_val("err",       32'(err),       32'(x.err));
      check_val("err_cnt",   32'(err_cnt),   32'(x.err_cnt));
      check_val("rot_cnt",   32'(rot_cnt),   32'(x.rot_cnt));
    end
  endtask

  task automatic s(input logic [3:0] v);
    step(1'b0, 1'b1, 1'b0, v);
  endtask

  task automatic relock();
    s(4'b0001); s(4'b1000); s(4'b0100);
  endtask

  initial begin
    logic [3:0] rot_seq [4];
    logic [3:0] rv;
    rot_seq[0] = 4'b0100; rot_seq[1] = 4'b0010;
    rot_seq[2] = 4'b0001; rot_seq[3] = 4'b1000;
    rst = 1'b1; en = 1'b0; clr_cnt = 1'b0; ring_in = '0;

    step(1'b1, 1'b0, 1'b0, 4'b0000);
    step(1'b1, 1'b1, 1'b1, 4'b0001);
    check_val("reset_locked", 32'(locked), 0);
    check_val("reset_idx_valid", 32'(idx_valid), 0);

    // lock acquisition
    s(4'b0001); check_val("acq_idx0", 32'(idx), 0); check_val("acq_lock0", 32'(locked), 0);
    s(4'b1000); check_val("acq_idx3", 32'(idx), 3); check_val("acq_lock1", 32'(locked), 0);
    s(4'b0100); check_val("acq_idx2", 32'(idx), 2); check_val("acq_locked", 32'(locked), 1);

    // wrap counting
    s(4'b0010); s(4'b0001);
    s(4'b1000); check_val("wrap_pulse", 32'(wrap), 1); check_val("rot1", 32'(rot_cnt), 1);
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++) s(rot_seq[j]);
    check_val("rot5", 32'(rot_cnt), 5);

    // sequence error: prev=0010, expected 0001, feed 0100
    s(4'b0100); s(4'b0010);
    s(4'b0100);
    check_val("seq_err", 32'(err), 1); check_val("seq_errcnt", 32'(err_cnt), 1);
    check_val("seq_unlock", 32'(locked), 0);
    s(4'b0010); check_val("relock_wait", 32'(locked), 0);
    s(4'b0001); check_val("relock", 32'(locked), 1);

    // non-one-hot while locked, then 0000 in SEARCH
    s(4'b0110);
    check_val("noh_err", 32'(err), 1); check_val("noh_iv", 32'(idx_valid), 0);
    check_val("noh_idx_hold", 32'(idx), 0);
    s(4'b0000); check_val("zero_no_err", 32'(err), 0);
    s(4'b1000); s(4'b0100); check_val("fresh_not_locked", 32'(locked), 0);
    s(4'b0010); check_val("fresh_locked", 32'(locked), 1);

    // enable gaps with junk inputs
    s(4'b0001);
    step(1'b0, 1'b0, 1'b0, 4'b1111);
    step(1'b0, 1'b0, 1'b0, 4'b0100);
    s(4'b1000);
    step(1'b0, 1'b0, 1'b0, 4'b0000);
    check_val("gap_hold_lock", 32'(locked), 1); check_val("gap_no_wrap", 32'(wrap), 0);
    s(4'b0100); check_val("gap_still_locked", 32'(locked), 1);

    // saturation: 300 errors, each followed by a relock
    for (int k = 0; k < 300; k++) begin
      s(4'b0000);
      relock();
    end
    check_val("err_sat", 32'(err_cnt), 255);

    // clear coinciding with an error
    step(1'b0, 1'b1, 1'b1, 4'b1111);
    check_val("clr_err_pulse", 32'(err), 1); check_val("clr_errcnt", 32'(err_cnt), 0);

    // reset mid-operation with rot_cnt=3
    s(4'b0000); relock();
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 4; j++) s(rot_seq[(j + 1) % 4]);
    check_val("pre_rst_rot", 32'(rot_cnt), 3);
    step(1'b1, 1'b1, 1'b0, 4'b0001);
    check_val("rst_rot", 32'(rot_cnt), 0); check_val("rst_locked", 32'(locked), 0);
    s(4'b0010); s(4'b0001); check_val("post_rst_wait", 32'(locked), 0);
    s(4'b1000); check_val("post_rst_lock", 32'(locked), 1);

    // random mix of legal and illegal samples, gaps and clears
    rv = 4'b1000;
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 9))
        0:       step(1'b0, 1'b1, 1'b0, 4'($urandom_range(0, 15)));
        1:       step(1'b0, 1'b0, 1'b0, 4'($urandom_range(0, 15)));
        2:       step(1'b0, 1'b1, ($urandom_range(0, 3) == 0), 4'b0001 << $urandom_range(0, 3));
        default: begin rv = {rv[0], rv[3:1]}; s(rv); end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
